// File: rtl/reg_file_17_if.sv
// Write/clear/read bundle between the operand select mux, reg_file_17 and the ALU operand path.
interface reg_file_17_if #(
  parameter int unsigned DATA_W = 17,
  parameter int unsigned ADDR_W = 3
);
  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic              write_en;
  logic [ADDR_W-1:0] write_addr;
  logic [DATA_W-1:0] write_data;
  logic              clear_all;
  logic [ADDR_W-1:0] read_addr_a;
  logic [DATA_W-1:0] read_data_a_c;
  logic [ADDR_W-1:0] read_addr_b;
  logic [DATA_W-1:0] read_data_b_c;
  logic [DEPTH-1:0]  dirty_mask;

  modport master (
    output write_en, write_addr, write_data, clear_all, read_addr_a, read_addr_b,
    input  read_data_a_c, read_data_b_c, dirty_mask
  );

  modport slave (
    input  write_en, write_addr, write_data, clear_all, read_addr_a, read_addr_b,
    output read_data_a_c, read_data_b_c, dirty_mask
  );
endinterface

// File: rtl/reg_file_17.sv
// Eight-entry 17-bit register file, R0 hardwired to zero, two combinational read ports and a dirty mask.
// Optional same-cycle write-to-read forwarding is enabled by defining REGFILE_BYPASS_EN.
module reg_file_17 #(
  parameter int unsigned DATA_W = 17,
  parameter int unsigned ADDR_W = 3
) (
  input  logic          clk,
  input  logic          rst,
  reg_file_17_if.slave  bus
);
  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DEPTH-1:0]  dirty_q;
  logic              wr_hit_c;
  logic              byp_a_c;
  logic              byp_b_c;
  logic [DATA_W-1:0] stored_a_c;
  logic [DATA_W-1:0] stored_b_c;

  // A write lands only when not cleared and not aimed at the zero register
  assign wr_hit_c = bus.write_en && !bus.clear_all && (bus.write_addr != '0);

  // Storage and dirty tracking; clear wins over a same-cycle write
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        regs_q[i] <= '0;
      end
      dirty_q <= '0;
    end else if (bus.clear_all) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        regs_q[i] <= '0;
      end
      dirty_q <= '0;
    end else if (wr_hit_c) begin
      regs_q[bus.write_addr]  <= bus.write_data;
      dirty_q[bus.write_addr] <= 1'b1;
    end
  end

  // Address 0 is decoded to zero explicitly rather than relying on regs_q[0]
  always_comb begin
    stored_a_c = '0;
    stored_b_c = '0;
    if (bus.read_addr_a != '0) stored_a_c = regs_q[bus.read_addr_a];
    if (bus.read_addr_b != '0) stored_b_c = regs_q[bus.read_addr_b];
  end

`ifdef REGFILE_BYPASS_EN
  assign byp_a_c = wr_hit_c && !rst && (bus.write_addr == bus.read_addr_a);
  assign byp_b_c = wr_hit_c && !rst && (bus.write_addr == bus.read_addr_b);
`else
  assign byp_a_c = 1'b0;
  assign byp_b_c = 1'b0;
`endif

  assign bus.read_data_a_c = byp_a_c ? bus.write_data : stored_a_c;
  assign bus.read_data_b_c = byp_b_c ? bus.write_data : stored_b_c;
  assign bus.dirty_mask    = dirty_q;
endmodule

// File: doc/reg_file_17.md
# reg_file_17

Eight-entry, 17-bit register file that sits directly downstream of the constant/operand select mux in the single-cycle datapath. It captures the mux's 17-bit result on a clock edge and provides two combinational read ports to the ALU operand path. It also tracks which registers have been written since the last reset or clear.

## Interface

Parameters:
- DATA_W, 17, width of every register and of the write/read data.
- ADDR_W, 3, register address width; depth is 2**ADDR_W (8).

Ports (one clock; reset is asynchronous and active-high):
- Clock  in  1  rising-edge clock for all state.
- Reset  in  1  asynchronous, active-high; clears every register and DirtyMask.
- WriteEn  in  1  write strobe, sampled on the Clock rising edge.
- WriteAddr  in  ADDR_W  destination register.
- WriteData  in  DATA_W  value to store; driven by the select mux Output.
- ClearAll  in  1  synchronous clear strobe for all registers and DirtyMask.
- ReadAddrA  in  ADDR_W  port A address.
- ReadDataA  out  DATA_W  port A data, combinational.
- ReadAddrB  in  ADDR_W  port B address.
- ReadDataB  out  DATA_W  port B data, combinational.
- DirtyMask  out  2**ADDR_W  bit i is 1 if register i has been written since the last Reset or ClearAll; registered.

## Operation

- Storage: registers R0..R7, each DATA_W bits.
- R0 is hardwired to zero:
  - Reads of address 0 always return 0.
  - Writes to address 0 are discarded.
  - DirtyMask[0] is constantly 0.
- Write: on a rising edge with WriteEn=1, ClearAll=0 and WriteAddr≠0:
  - R[WriteAddr] takes WriteData.
  - DirtyMask[WriteAddr] is set to 1.
- ClearAll: on a rising edge with ClearAll=1:
  - All registers and all DirtyMask bits go to 0.
  - ClearAll takes priority over WriteEn; a write in the same cycle is dropped.
- Reads:
  - ReadDataA = R[ReadAddrA] and ReadDataB = R[ReadAddrB].
  - Both are purely combinational from current state.
  - Both ports may address the same register; both return the same value.
- Width: WriteData is stored as-is with no truncation or extension; all DATA_W bits round-trip.
- Reset (asserted at any time, including mid-cycle or during a write):
  - All registers go to 0 and DirtyMask goes to 0 immediately, without waiting for a clock edge.
  - ReadDataA and ReadDataB read 0 while Reset is held.
  - Writes and ClearAll are ignored while Reset=1.
- Rewriting an already-dirty register keeps its DirtyMask bit at 1.

## Timing

- Write latency: a value written at edge N is visible on the read ports from just after edge N.
- Read latency: zero cycles, combinational from address and state.
- Same-cycle read/write of one address: default behaviour returns the old value (see Configuration).
- DirtyMask updates on the same edge as the write or clear it reflects.
- Reset release: the first edge with Reset=0 may perform a write.
- No handshake and no stall; one write per cycle is accepted unconditionally.

## Configuration

- Macro: REGFILE_BYPASS_EN.
- Defined: each read port forwards WriteData combinationally when all of the following hold:
  - WriteEn=1, ClearAll=0 and Reset=0;
  - WriteAddr equals that port's address;
  - the address is not 0.
  - This gives a write-then-read result within the same cycle.
- Undefined: no forwarding; same-cycle reads return the pre-edge stored value.
- Storage, DirtyMask and priority rules are identical in both builds.

## Test plan

- Reset check: assert Reset with registers preloaded.
  - All ReadData outputs read 0 and DirtyMask=8'h00 before any clock edge.
- Basic write/read: write 17'h1ABCD to R3, then 17'h00001 to R7.
  - ReadAddrA=3 returns 17'h1ABCD and ReadAddrB=7 returns 17'h00001.
  - DirtyMask=8'h88.
- R0 protection: write 17'h1FFFF to address 0.
  - Reads of address 0 return 0; DirtyMask[0]=0.
- ClearAll priority: with R5=17'h00123, apply ClearAll=1 and WriteEn=1 to R2 with 17'h00055 in the same cycle.
  - All reads return 0; DirtyMask=8'h00.
- Same-cycle bypass: R4=17'h00010; write 17'h00020 to R4 while ReadAddrA=4, before the edge.
  - With REGFILE_BYPASS_EN, ReadDataA=17'h00020.
  - Without it, ReadDataA=17'h00010.
  - After the edge, both builds read 17'h00020.
- Async reset mid-write: assert Reset between edges while WriteEn=1 to R6 with 17'h0AAAA, and hold it across the next edge.
  - R6 reads 0 and DirtyMask=8'h00 after Reset is released.
